// File: rtl/dp_ram.sv
// True dual-port synchronous RAM with registered read data and port-1 write priority.
// Optional macro DPRAM_COLLISION_FWD_EN forwards opposite-port write data on a same-address read.
module dp_ram #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 11
) (
    input  logic              CLK,
    input  logic              nRES,
    input  logic              nCE,
    input  logic              nWE,
    input  logic              nOE,
    input  logic [AWIDTH-1:0] A,
    input  logic [DWIDTH-1:0] DI,
    output logic [DWIDTH-1:0] DO,
    input  logic              nCE2,
    input  logic              nWE2,
    input  logic              nOE2,
    input  logic [AWIDTH-1:0] A2,
    input  logic [DWIDTH-1:0] DI2,
    output logic [DWIDTH-1:0] DO2
);
    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [0:DEPTH-1];
    logic [DWIDTH-1:0] r_do, r_do2;
    logic              w_wr1, w_rd1, w_wr2, w_rd2;
    logic [DWIDTH-1:0] w_rdata1, w_rdata2;

    // Reset gates the enables, so no write can land while nRES is low.
    assign w_wr1 = nRES & ~nCE  & ~nWE;
    assign w_rd1 = nRES & ~nCE  &  nWE  & ~nOE;
    assign w_wr2 = nRES & ~nCE2 & ~nWE2;
    assign w_rd2 = nRES & ~nCE2 &  nWE2 & ~nOE2;

`ifdef DPRAM_COLLISION_FWD_EN
    assign w_rdata1 = (w_wr2 && (A2 == A)) ? DI2 : mem[A];
    assign w_rdata2 = (w_wr1 && (A == A2)) ? DI  : mem[A2];
`else
    assign w_rdata1 = mem[A];
    assign w_rdata2 = mem[A2];
`endif

    // Port-1 write is issued last so it wins a same-address double write.
    always_ff @(posedge CLK) begin
        if (w_wr2) mem[A2] <= DI2;
        if (w_wr1) mem[A]  <= DI;
    end

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            r_do  <= '0;
            r_do2 <= '0;
        end else begin
            if (w_rd1) r_do  <= w_rdata1;
            if (w_rd2) r_do2 <= w_rdata2;
        end
    end

    assign DO  = r_do;
    assign DO2 = r_do2;
endmodule

// File: tb/tb_dp_ram.sv
// Directed plus randomized bench for dp_ram against an array-based reference model.
module tb_dp_ram;
    localparam int DW    = 8;
    localparam int AW    = 11;
    localparam int DEPTH = 1 << AW;
`ifdef DPRAM_COLLISION_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          nRES, nCE, nWE, nOE, nCE2, nWE2, nOE2;
    logic [AW-1:0] A, A2;
    logic [DW-1:0] DI, DI2;
    logic [DW-1:0] DO, DO2;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_do, exp_do2;
    int            n_chk = 0;
    int            n_pass = 0;

    always #5 CLK = ~CLK;

    dp_ram #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .CLK(CLK), .nRES(nRES),
        .nCE(nCE), .nWE(nWE), .nOE(nOE), .A(A), .DI(DI), .DO(DO),
        .nCE2(nCE2), .nWE2(nWE2), .nOE2(nOE2), .A2(A2), .DI2(DI2), .DO2(DO2)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle; controls are {nCE,nWE,nOE} per port. Model resolves outputs from the
    // memory state before the edge, then applies writes with port 1 last (priority).
    task automatic step(input logic rst_n,
                        input logic [2:0] c1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [2:0] c2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                        input string tag);
        logic wr1, rd1, wr2, rd2;
        nRES = rst_n;
        {nCE, nWE, nOE}    = c1; A  = a1; DI  = d1;
        {nCE2, nWE2, nOE2} = c2; A2 = a2; DI2 = d2;
        wr1 = rst_n && !c1[2] && !c1[1];
        rd1 = rst_n && !c1[2] &&  c1[1] && !c1[0];
        wr2 = rst_n && !c2[2] && !c2[1];
        rd2 = rst_n && !c2[2] &&  c2[1] && !c2[0];
        if (!rst_n) begin
            exp_do  = '0;
            exp_do2 = '0;
        end else begin
            if (rd1) exp_do  = (FWD && wr2 && a2 == a1) ? d2 : ref_mem[a1];
            if (rd2) exp_do2 = (FWD && wr1 && a1 == a2) ? d1 : ref_mem[a2];
            if (wr2) ref_mem[a2] = d2;
            if (wr1) ref_mem[a1] = d1;
        end
        @(posedge CLK);
        #1;
        check({tag, ".DO"},  DO,  exp_do);
        check({tag, ".DO2"}, DO2, exp_do2);
    endtask

    localparam logic [2:0] IDL = 3'b111;
    localparam logic [2:0] RD  = 3'b010;
    localparam logic [2:0] WR  = 3'b001;

    initial begin
        logic [DW-1:0] held;
        logic [2:0]    c1, c2;
        logic [AW-1:0] ra1, ra2;

        step(1'b0, IDL, '0, '0, IDL, '0, '0, "reset0");
        step(1'b0, IDL, '0, '0, IDL, '0, '0, "reset1");

        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = DW'($urandom);
            dut.mem[i] = ref_mem[i];
        end
        ref_mem[5] = 8'hA5; dut.mem[5] = 8'hA5;
        ref_mem[3] = 8'h00; dut.mem[3] = 8'h00;
        ref_mem[0] = 8'h55; dut.mem[0] = 8'h55;

        step(1'b1, RD, 11'd5, '0, IDL, '0, '0, "preload");
        check("preload_A5", DO, 8'hA5);

        step(1'b1, WR, 11'h7FF, 8'h3C, IDL, '0, '0, "wr7ff");
        check("do_hold_on_write", DO, 8'hA5);
        step(1'b1, IDL, '0, '0, RD, 11'h7FF, '0, "rd7ff");
        check("p2_read_7ff", DO2, 8'h3C);

        step(1'b1, WR, 11'd10, 8'h11, WR, 11'd10, 8'h22, "dblwr");
        step(1'b1, RD, 11'd10, '0, RD, 11'd10, '0, "dblwr_rd");
        check("dblwr_p1", DO, 8'h11);
        check("dblwr_p2", DO2, 8'h11);

        step(1'b1, WR, 11'd3, 8'hFF, RD, 11'd3, '0, "rwcol1");
        check("rwcol_p2", DO2, FWD ? 8'hFF : 8'h00);
        step(1'b1, RD, 11'd3, '0, WR, 11'd3, 8'h77, "rwcol2");
        check("rwcol_p1", DO, FWD ? 8'h77 : 8'hFF);

        step(1'b0, WR, 11'd0, 8'hEE, WR, 11'd0, 8'hEE, "rstwr0");
        step(1'b0, WR, 11'd0, 8'hEE, WR, 11'd0, 8'hEE, "rstwr1");
        check("rst_do", DO, 8'h00);
        check("rst_do2", DO2, 8'h00);
        check("rst_mem0", dut.mem[0], 8'h55);
        step(1'b1, RD, 11'd0, '0, RD, 11'd0, '0, "post_rst");
        check("post_rst_rd", DO, 8'h55);

        step(1'b1, RD, 11'd5, '0, IDL, '0, '0, "gate_set");
        held = DO;
        check("gate_set_val", held, 8'hA5);
        step(1'b1, 3'b011, 11'd1, '0, 3'b011, 11'd2, '0, "gate_oe0");
        check("gate_oe0_hold", DO, 8'hA5);
        step(1'b1, 3'b011, 11'd2, '0, 3'b110, 11'd3, '0, "gate_oe1");
        check("gate_oe1_hold", DO, 8'hA5);
        step(1'b1, 3'b110, 11'd3, '0, 3'b110, 11'd4, '0, "gate_ce");
        check("gate_ce_hold", DO, 8'hA5);

        for (int n = 0; n < 500; n++) begin
            c1  = 3'($urandom);
            c2  = 3'($urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            ra2 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            step(($urandom_range(0, 31) != 0), c1, ra1, DW'($urandom),
                 c2, ra2, DW'($urandom), "rand");
        end

        for (int i = 0; i < 8; i++) begin
            step(1'b1, RD, AW'(i), '0, RD, AW'(7 - i), '0, "sweep");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dp_ram.md
DP_RAM -- requirements
Module: dp_ram

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter AWIDTH, default 11, address width in bits; depth is 2^AWIDTH words.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port nRES  input  1  reset; synchronous, active-low.
REQ-005 SHALL have ports nCE, nWE, nOE  input  1 each  port-1 chip enable, write enable and output enable; all active-low.
REQ-006 SHALL have port A  input  AWIDTH  port-1 address.
REQ-007 SHALL have port DI  input  DWIDTH  port-1 write data.
REQ-008 SHALL have port DO  output  DWIDTH  port-1 registered read data.
REQ-009 SHALL have ports nCE2, nWE2, nOE2, A2, DI2, DO2, identical to port 1, for port 2.
REQ-010 SHALL hold storage in an unpacked array named mem[0:2^AWIDTH-1] of DWIDTH bits, so benches can preload it hierarchically.

Function
REQ-011 SHALL write mem[A] <= DI at the clock edge when nRES=1, nCE=0 and nWE=0; nOE is ignored for writes.
REQ-012 SHALL read DO <= mem[A] at the clock edge when nRES=1, nCE=0, nWE=1 and nOE=0; read latency is 1 clock.
REQ-013 SHALL hold DO at its last value in every other case: nCE=1, nOE=1, or a write cycle.
REQ-014 SHALL apply REQ-011 to REQ-013 to port 2 independently, using its own signals.
REQ-015 SHALL accept simultaneous writes to different addresses on both ports in the same cycle.
REQ-016 SHALL store port-1 data when both ports write the same address in the same cycle; the port-2 write is discarded.
REQ-017 SHALL return the pre-write contents (read-first) when one port reads an address the other port writes in the same cycle, unless REQ-022 applies.
REQ-018 SHALL support full-rate back-to-back accesses on each port, one per clock, with no bubbles; address wrap is implicit in AWIDTH.
REQ-019 SHALL treat X/Z-free inputs only; undriven port-2 inputs tied high leave port 2 idle.

Reset
REQ-020 SHALL, while nRES=0, force DO and DO2 to 0 at each clock edge and block all writes on both ports.
REQ-021 SHALL preserve mem contents across reset; no clear sweep is performed, and preloaded contents survive reset. Reset asserted mid-burst takes effect at the next edge, and the in-flight write does not occur.

Configuration
REQ-022 SHALL, when macro DPRAM_COLLISION_FWD_EN is defined, return the data being written by the opposite port (write-through forwarding) for a same-cycle, same-address read/write collision; with port-1 priority per REQ-016 if both ports write.
REQ-023 SHALL, without DPRAM_COLLISION_FWD_EN, use read-first behaviour per REQ-017; all other behaviour is identical.

Verification
REQ-024 Preload: after a hierarchical load with mem[5]=8'hA5, then nRES=1 and a port-1 read of A=5 with nCE=0, nWE=1, nOE=0 -> DO=8'hA5 one clock later.
REQ-025 Write/read: port-1 write A=11'h7FF, DI=8'h3C, then a port-2 read of A2=11'h7FF -> DO2=8'h3C after 1 clock; DO holds its prior value during the write.
REQ-026 Write collision: both ports write A=A2=10, DI=8'h11, DI2=8'h22, then read -> 8'h11.
REQ-027 R/W collision: mem[3]=8'h00; port 1 writes 8'hFF to 3 while port 2 reads 3 -> DO2=8'h00 without the macro, DO2=8'hFF with DPRAM_COLLISION_FWD_EN defined.
REQ-028 Reset: with mem[0]=8'h55, nRES=0 for 2 clocks while a write of 8'hEE to address 0 is requested -> DO=DO2=0 and mem[0] remains 8'h55; after release, a read of address 0 returns 8'h55.
REQ-029 Gating: a read with nOE=1 or nCE=1 -> DO unchanged across 3 clocks of changing A.
